// File: rtl/fifo_drain_stage.sv
// Pop-side drain stage: 2-entry skid buffer between a FIFO and a
// valid/ready consumer, with an optional burst/gap pop throttle.
module fifo_drain_stage #(
  parameter int DATAW = 1,
  parameter int BURST = 0,
  parameter int GAP   = 1,
  parameter int CNTW  = $clog2(((BURST > GAP) ? BURST : GAP) + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [DATAW-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out,
  output logic [1:0]       occupancy,
  output logic             throttled
);

  typedef enum logic {
    S_RUN,
    S_GAP
  } state_e;

  localparam bit THROTTLE = (BURST > 0);
  localparam logic [CNTW-1:0] BURST_LAST =
    CNTW'((BURST > 0) ? BURST - 1 : 0);
  localparam logic [CNTW-1:0] GAP_LAST =
    CNTW'((GAP > 0) ? GAP - 1 : 0);

  logic [DATAW-1:0] head_q, head_d;
  logic [DATAW-1:0] skid_q, skid_d;
  logic [1:0]       occ_q, occ_d;
  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic pop;
  logic xfer;
  logic ld_head;
  logic ld_skid;
  logic shift;

  // Pop depends only on registered state and FIFO-side inputs.
  assign pop = reset_n & enable & ~flush & ~fifo_empty
             & (occ_q != 2'd2) & (state_q == S_RUN);
  assign xfer = valid_out & ready_out & ~flush;

  assign ld_head = pop & ((occ_q == 2'd0) | xfer);
  assign ld_skid = pop & ~ld_head;
  assign shift   = xfer & (occ_q == 2'd2);

  assign fifo_pop  = pop;
  assign valid_out = (occ_q != 2'd0);
  assign data_out  = head_q;
  assign occupancy = occ_q;
  assign throttled = (state_q == S_GAP);

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      unique case (1'b1)
        shift:   head_d = skid_q;
        ld_head: head_d = fifo_data;
        ld_skid: skid_d = fifo_data;
        default: ;
      endcase
      occ_d = occ_q + {1'b0, pop} - {1'b0, xfer};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!THROTTLE || flush) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (pop) begin
            if (cnt_q == BURST_LAST) begin
              cnt_d   = '0;
              state_d = S_GAP;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      skid_q  <= '0;
      occ_q   <= 2'd0;
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  a_hold: assert property (
    @(posedge clk) disable iff (!reset_n)
    (valid_out && !ready_out && !flush)
      |=> (valid_out && $stable(data_out))
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (!reset_n)
    fifo_empty |-> !fifo_pop
  );

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Bench for fifo_drain_stage: unthrottled and BURST=4/GAP=3 instances
// driven in lockstep, checked against a queue-based reference model.
module tb_fifo_drain_stage;

  localparam int B1 = 4;
  localparam int G1 = 3;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       flush;
  logic       ready_out;
  logic       fifo_empty [2];
  logic [7:0] fifo_data  [2];
  logic       fifo_pop   [2];
  logic       valid_out  [2];
  logic [7:0] data_out   [2];
  logic [1:0] occupancy  [2];
  logic       throttled  [2];

  logic [7:0] src  [2][$];
  logic [7:0] expq [2][$];
  int         burst_n [2];
  int         gap_n   [2];

  int cmp_cnt = 0;
  int bad_cnt = 0;

  fifo_drain_stage #(.DATAW(8), .BURST(0), .GAP(1)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
    .fifo_pop(fifo_pop[0]), .valid_out(valid_out[0]),
    .data_out(data_out[0]), .ready_out(ready_out),
    .occupancy(occupancy[0]), .throttled(throttled[0])
  );

  fifo_drain_stage #(.DATAW(8), .BURST(B1), .GAP(G1)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
    .fifo_pop(fifo_pop[1]), .valid_out(valid_out[1]),
    .data_out(data_out[1]), .ready_out(ready_out),
    .occupancy(occupancy[1]), .throttled(throttled[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s[%0d] t=%0t got %0h expected %0h",
               nm, i, $time, act, exp);
    end
  endtask

  // Monitor: the head of the held-entry queue must be on data_out.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset_n === 1'b1 && valid_out[i] === 1'b1) begin
        if (expq[i].size() == 0) begin
          chk("spurious_valid", i, {31'd0, valid_out[i]}, 32'd0);
        end else begin
          chk("data_out", i, {24'd0, data_out[i]}, {24'd0, expq[i][0]});
          if (ready_out && !flush) void'(expq[i].pop_front());
        end
      end
    end
  end

  task automatic load(logic [7:0] d);
    src[0].push_back(d);
    src[1].push_back(d);
  endtask

  task automatic step(bit en, bit rdy, bit fl, bit rs);
    bit mp [2];
    @(posedge clk);
    #1;
    enable    = en;
    ready_out = rdy;
    flush     = fl;
    reset_n   = rs;
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = (src[i].size() == 0);
      fifo_data[i]  = (src[i].size() == 0) ? 8'h00 : src[i][0];
      if (!rs) begin
        expq[i].delete();
        burst_n[i] = 0;
        gap_n[i]   = 0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      mp[i] = rs && en && !fl && src[i].size() != 0
              && expq[i].size() < 2 && gap_n[i] == 0;
      chk("fifo_pop", i, {31'd0, fifo_pop[i]}, {31'd0, mp[i]});
      chk("occupancy", i, {30'd0, occupancy[i]}, expq[i].size());
      chk("valid_out", i, {31'd0, valid_out[i]},
          {31'd0, expq[i].size() != 0});
      chk("throttled", i, {31'd0, throttled[i]}, {31'd0, gap_n[i] != 0});
      if (!rs) chk("reset_data", i, {24'd0, data_out[i]}, 32'd0);
      if (mp[i]) expq[i].push_back(src[i][0]);
    end
    #5;
    for (int i = 0; i < 2; i++) begin
      if (mp[i]) void'(src[i].pop_front());
      if (rs && fl) begin
        expq[i].delete();
        burst_n[i] = 0;
        gap_n[i]   = 0;
      end else if (rs && i == 1) begin
        if (gap_n[i] > 0) begin
          gap_n[i]--;
        end else if (mp[i]) begin
          burst_n[i]++;
          if (burst_n[i] == B1) begin
            burst_n[i] = 0;
            gap_n[i]   = G1;
          end
        end
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    flush     = 1'b0;
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = 1'b1;
      fifo_data[i]  = 8'h00;
      burst_n[i]    = 0;
      gap_n[i]      = 0;
    end

    load(8'h01); load(8'h02); load(8'h03);
    repeat (2) step(1, 1, 0, 0);
    repeat (6) step(1, 1, 0, 1);

    load(8'h05); load(8'h06); load(8'h07);
    repeat (4) step(1, 0, 0, 1);
    repeat (5) step(1, 1, 0, 1);

    step(1, 1, 1, 1);
    for (int k = 0; k < 10; k++) load(8'h10 + 8'(k));
    repeat (18) step(1, 1, 0, 1);

    load(8'h21); load(8'h22); load(8'h23);
    repeat (3) step(1, 0, 0, 1);
    step(1, 1, 1, 1);
    repeat (6) step(1, 1, 0, 1);

    step(1, 1, 1, 1);
    for (int k = 0; k < 10; k++) load(8'h30 + 8'(k));
    repeat (5) step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    repeat (14) step(1, 1, 0, 1);

    for (int k = 0; k < 4; k++) load(8'h40 + 8'(k));
    step(1, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    repeat (2) step(0, 1, 0, 1);
    repeat (8) step(1, 1, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) < 60 && src[0].size() < 8
          && src[1].size() < 8)
        load(8'($urandom));
    end

    repeat (40) step(1, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_drain_stage.md
Name: fifo_drain_stage

Overview:
- Pop-side stage placed directly downstream of the FIFO queue; it sits between the FIFO's empty, data_out and pop signals and a valid/ready consumer.
- Pulls entries into a 2-entry skid buffer and presents them on a registered valid/ready output with full throughput.
- Optional burst throttle: after BURST pops, FIFO pops are suspended for GAP cycles (rate limiting toward shared interconnect).

Parameters:
- DATAW, 1, entry width in bits.
- BURST, 0, pops allowed per burst window; 0 disables throttling.
- GAP, 1, idle cycles inserted after each burst; must be >= 1 when BURST > 0.
- CNTW, $clog2(((BURST > GAP) ? BURST : GAP) + 1), burst/gap counter width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permits new FIFO pops; held entries drain regardless.
- flush  in  1  synchronous discard of held entries and throttle state.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATAW  FIFO head data, valid in the same cycle whenever fifo_empty=0.
- fifo_pop  out  1  pop strobe to the FIFO.
- valid_out  out  1  output holds an entry.
- data_out  out  DATAW  output entry (head of the skid buffer).
- ready_out  in  1  consumer accepts; transfer = valid_out & ready_out.
- occupancy  out  2  entries held (0..2).
- throttled  out  1  1 while in the GAP state.

Behaviour:
- Reset (reset_n=0, async assert): occupancy=0, valid_out=0, data_out=0, skid register=0, state=RUN, counter=0, throttled=0.
- fifo_pop is forced to 0 while reset_n=0.
- Reset deassertion takes effect on the next clk edge.
- fifo_pop = enable & !flush & !fifo_empty & (occupancy<2) & (state==RUN). It is combinational from registered state and inputs; there are no comb paths from ready_out to fifo_pop.
- Popped fifo_data is captured at the same edge; zero extra latency.
  - Empty stage: the entry appears on valid_out/data_out in the next cycle.
- Storage: head register plus skid register.
  - Transfer with occupancy=2: skid moves to head.
  - Pop with occupancy=0, or with occupancy=1 plus a same-cycle transfer: fifo_data goes into head.
  - Otherwise a pop writes the skid register.
  - FIFO order is preserved.
- occupancy_next = occupancy + pop - transfer; never exceeds 2 or underflows.
- valid_out = (occupancy != 0). data_out only changes on a transfer or on a load into an empty head.
- Steady stream with ready_out=1: one pop and one transfer per cycle, occupancy stays 1.
- Throttle FSM (only when BURST>0; with BURST=0 state stays RUN permanently):
  - RUN: counter increments on each fifo_pop. On the pop that makes counter==BURST: counter<=0, state<=GAP.
  - GAP: throttled=1, no pops. Counter increments each cycle; when counter==GAP-1: counter<=0, state<=RUN.
  - A burst ends after exactly BURST pops and is followed by exactly GAP pop-free cycles.
  - Transfers from held entries continue during GAP.
- flush=1 at an edge:
  - occupancy<=0, valid_out<=0, state<=RUN, counter<=0.
  - No pop that cycle; a same-cycle transfer is ignored.
  - data_out holds its value (don't-care while invalid).
- enable=0: no pops. The throttle counter holds in RUN and keeps counting in GAP.
- fifo_empty=1 in RUN: no pop, counter holds.
- Async reset mid-burst: all state returns to reset values immediately; the burst restarts from 0 after release.
- Assertions (simulation only):
  - valid_out stays stable and data_out stays unchanged while valid_out=1 and ready_out=0.
  - fifo_pop never asserts while fifo_empty=1.

Test Plan:
- Reset released, FIFO preloaded 0x1,0x2,0x3, ready_out=1, BURST=0 -> fifo_pop high 3 consecutive cycles; data_out 0x1,0x2,0x3 on consecutive cycles starting 1 cycle after the first pop; occupancy stays 1 then returns to 0.
- ready_out=0, FIFO holding 0x5,0x6,0x7 -> exactly 2 pops, occupancy=2, data_out=0x5 held stable. Raise ready_out -> outputs 0x5,0x6,0x7 in order, no bubble, 3rd pop occurs the cycle after the first transfer.
- BURST=4, GAP=3, FIFO with 10 entries, ready_out=1 -> pops in cycles 0-3, throttled=1 for cycles 4-6, pops resume cycle 7; 10 entries delivered in order.
- occupancy=2 with flush=1 and ready_out=1 in the same cycle -> next cycle occupancy=0, valid_out=0, no fifo_pop in the flush cycle, throttle counter=0.
- reset_n pulsed low mid-GAP (BURST=2, GAP=5) -> throttled=0, valid_out=0 immediately; after release a full 2-pop burst occurs before the next gap.
- enable=0 with a non-empty FIFO and occupancy=1 -> no pops; the held entry transfers when ready_out=1; pops resume the cycle enable returns to 1.
